// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - op codes, FSM states and op classification for the shift sequencer (honours SHIFT_SEQ_ROTATE_EN)
package shift_seq_pkg;

  typedef enum logic [2:0] {
    OP_LSR = 3'b000,
    OP_LSL = 3'b001,
    OP_ASR = 3'b010,
    OP_ASL = 3'b011,
    OP_ROR = 3'b100,
    OP_ROL = 3'b101
  } opT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_RESP  = 2'b10
  } stateT;

  localparam logic [2:0] OP_ILLEGAL_6 = 3'b110;
  localparam logic [2:0] OP_ILLEGAL_7 = 3'b111;

  function automatic logic isRotate(input logic [2:0] op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

  // Rotates count as legal only when the rotate datapath is built.
  function automatic logic isLegal(input logic [2:0] op);
`ifdef SHIFT_SEQ_ROTATE_EN
    return !((op == OP_ILLEGAL_6) || (op == OP_ILLEGAL_7));
`else
    return !op[2];
`endif
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - two-requester command bus and response bus of the shift sequencer
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_data;
  logic [AMT_W-1:0] req0_amt;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_data;
  logic [AMT_W-1:0] req1_amt;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_data, req0_amt,
    input  req1_valid, req1_op, req1_data, req1_amt,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_op, req0_data, req0_amt,
    output req1_valid, req1_op, req1_data, req1_amt,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - single 1-bit shift/rotate step (rotate paths only with SHIFT_SEQ_ROTATE_EN)
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // One-bit move selected by op; anything unrecognised passes through untouched.
  always_comb begin
    data_out = data_in;
    case (op)
      OP_LSR:         data_out = {1'b0, data_in[WIDTH-1:1]};
      OP_LSL, OP_ASL: data_out = {data_in[WIDTH-2:0], 1'b0};
      OP_ASR:         data_out = {data_in[WIDTH-1], data_in[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR:         data_out = {data_in[0], data_in[WIDTH-1:1]};
      OP_ROL:         data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
`endif
      default:        data_out = data_in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - round-robin two-requester iterative shifter (rotates enabled by SHIFT_SEQ_ROTATE_EN)
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  shift_sequencer_if.slave bus
);

  stateT            state;
  stateT            nextState;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             lastGrant;
  logic [2:0]       selOp;
  logic [WIDTH-1:0] selData;
  logic [AMT_W-1:0] selCount;
  logic [2:0]       capOp;
  logic [WIDTH-1:0] workData;
  logic [WIDTH-1:0] stepOut;
  logic [AMT_W-1:0] remaining;
  logic             rspId;
  logic [WIDTH-1:0] rspData;
  logic             rspErr;

  // Shifts saturate at WIDTH steps, rotates run the full amount, illegal ops run none.
  function automatic logic [AMT_W-1:0] iterCount(input logic [2:0] op, input logic [AMT_W-1:0] amt);
    if (!isLegal(op)) return '0;
    if (isRotate(op)) return amt;
    if (int'(amt) >= WIDTH) return AMT_W'(WIDTH);
    return amt;
  endfunction

  // Round-robin grant: on a tie the requester not granted last wins.
  always_comb begin
    grant1   = bus.req1_valid && (!bus.req0_valid || !lastGrant);
    grant0   = bus.req0_valid && !grant1;
    accept   = (state == ST_IDLE) && (grant0 || grant1);
    selOp    = grant1 ? bus.req1_op   : bus.req0_op;
    selData  = grant1 ? bus.req1_data : bus.req0_data;
    selCount = iterCount(selOp, grant1 ? bus.req1_amt : bus.req0_amt);
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op       (capOp),
    .data_in  (workData),
    .data_out (stepOut)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nextState;
  end

  // Next-state decode.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:  if (accept) nextState = (selCount != '0) ? ST_SHIFT : ST_RESP;
      ST_SHIFT: if (remaining == AMT_W'(1)) nextState = ST_RESP;
      ST_RESP:  if (bus.rsp_ready) nextState = ST_IDLE;
      default:  nextState = ST_IDLE;
    endcase
  end

  // Handshake and status outputs; response fields come straight from their registers.
  always_comb begin
    bus.req0_ready = (state == ST_IDLE) && grant0;
    bus.req1_ready = (state == ST_IDLE) && grant1;
    bus.rsp_valid  = (state == ST_RESP);
    bus.busy       = (state != ST_IDLE);
    bus.rsp_id     = rspId;
    bus.rsp_data   = rspData;
    bus.rsp_err    = rspErr;
  end

  // Command capture, per-cycle stepping and result latch (result only written on entry to RESP).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lastGrant <= 1'b1;
      rspId     <= 1'b0;
      rspData   <= '0;
      rspErr    <= 1'b0;
      capOp     <= '0;
      workData  <= '0;
      remaining <= '0;
    end else if (accept) begin
      lastGrant <= grant1;
      rspId     <= grant1;
      capOp     <= selOp;
      workData  <= selData;
      remaining <= selCount;
      if (selCount == '0) begin
        rspData <= selData;
        rspErr  <= !isLegal(selOp);
      end
    end else if (state == ST_SHIFT) begin
      workData  <= stepOut;
      remaining <= remaining - AMT_W'(1);
      if (remaining == AMT_W'(1)) begin
        rspData <= stepOut;
        rspErr  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer (expectations follow SHIFT_SEQ_ROTATE_EN)
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int WIDTH = 4;
  localparam int AMT_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   passCount = 0;
  int   checkCount = 0;

  always #5 clk = ~clk;

  // Cycle index used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic driveReq(input int r, input logic v, input logic [2:0] op,
                          input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_data = d; bus.req0_amt = a;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_data = d; bus.req1_amt = a;
    end
  endtask

  task automatic runCmd(input int r, input logic [2:0] op, input logic [WIDTH-1:0] d,
                        input logic [AMT_W-1:0] a, output int lat, output logic id,
                        output logic [WIDTH-1:0] data, output logic err, output logic ok);
    int tAcc;
    ok = 1'b0; lat = -1; id = 1'b0; data = '0; err = 1'b0; tAcc = 0;
    @(negedge clk);
    driveReq(r, 1'b1, op, d, a);
    #1;
    for (int i = 0; i < 20; i++) begin
      if ((r == 0 && bus.req0_ready) || (r == 1 && bus.req1_ready)) begin
        tAcc = cyc; ok = 1'b1; break;
      end
      @(negedge clk); #1;
    end
    if (!ok) begin
      driveReq(r, 1'b0, op, d, a);
      return;
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      driveReq(r, 1'b0, op, d, a);
      #1;
      if (bus.rsp_valid) begin
        lat = cyc - tAcc; id = bus.rsp_id; data = bus.rsp_data; err = bus.rsp_err; ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkCount++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); else passCount++;
    checkCount++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passCount++;
    checkCount++; if (bus.rsp_id !== 1'b0) $display("FAIL reset_rsp_id got %b want 0", bus.rsp_id); else passCount++;
    checkCount++; if (bus.rsp_data !== 4'b0000) $display("FAIL reset_rsp_data got %b want 0000", bus.rsp_data); else passCount++;
    checkCount++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err got %b want 0", bus.rsp_err); else passCount++;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic             got;
    logic             gId;
    logic             sId;
    logic [WIDTH-1:0] sData;
    logic             sErr;
    @(negedge clk);
    driveReq(0, 1'b1, OP_LSR, 4'b1000, 3'd1);
    driveReq(1, 1'b1, OP_LSL, 4'b0011, 3'd1);
    #1;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0; gId = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (bus.req0_ready || bus.req1_ready) begin
          got = 1'b1; gId = bus.req1_ready;
          checkCount++; if (bus.req0_ready && bus.req1_ready) $display("FAIL rr_one_ready got both want one"); else passCount++;
          break;
        end
        @(negedge clk); #1;
      end
      checkCount++; if (got !== 1'b1 || gId !== 1'(n % 2)) $display("FAIL rr_grant_%0d got %b(seen %b) want %0d", n, gId, got, n % 2); else passCount++;
      if (!got) break;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); #1;
        if (bus.rsp_valid) begin got = 1'b1; break; end
      end
      checkCount++; if (got !== 1'b1) $display("FAIL rr_rsp_timeout_%0d got none want rsp_valid", n); else passCount++;
      if (!got) break;
      sId = bus.rsp_id; sData = bus.rsp_data; sErr = bus.rsp_err;
      checkCount++; if (sId !== 1'(n % 2)) $display("FAIL rr_rsp_id_%0d got %b want %0d", n, sId, n % 2); else passCount++;
      checkCount++; if (sData !== ((n % 2 == 0) ? 4'b0100 : 4'b0110)) $display("FAIL rr_rsp_data_%0d got %b want %b", n, sData, (n % 2 == 0) ? 4'b0100 : 4'b0110); else passCount++;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk); #1;
        checkCount++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== sId || bus.rsp_data !== sData || bus.rsp_err !== sErr)
          $display("FAIL rr_stable_%0d_%0d got v%b id%b d%b e%b want v1 id%b d%b e%b", n, k,
                   bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, sId, sData, sErr);
        else passCount++;
      end
      checkCount++; if (bus.req0_ready || bus.req1_ready) $display("FAIL rr_ready_in_resp got %b%b want 00", bus.req1_ready, bus.req0_ready); else passCount++;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      if (n == 3) begin
        driveReq(0, 1'b0, OP_LSR, 4'b1000, 3'd1);
        driveReq(1, 1'b0, OP_LSL, 4'b0011, 3'd1);
      end
      #1;
    end
    @(negedge clk); #1;
    checkCount++; if (bus.busy !== 1'b0) $display("FAIL rr_idle_after got busy %b want 0", bus.busy); else passCount++;
  endtask

  task automatic test_lsr();
    int lat; logic id; logic [WIDTH-1:0] data; logic err; logic ok;
    runCmd(0, OP_LSR, 4'b0101, 3'd1, lat, id, data, err, ok);
    checkCount++; if (ok !== 1'b1) $display("FAIL lsr_done got timeout want response"); else passCount++;
    checkCount++; if (lat != 2) $display("FAIL lsr_latency got %0d want 2", lat); else passCount++;
    checkCount++; if (id !== 1'b0 || data !== 4'b0010 || err !== 1'b0) $display("FAIL lsr_result got id%b d%b e%b want id0 d0010 e0", id, data, err); else passCount++;
    checkCount++; if (bus.rsp_data !== 4'b0010 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL lsr_hold got d%b v%b b%b want d0010 v0 b0", bus.rsp_data, bus.rsp_valid, bus.busy); else passCount++;
  endtask

  task automatic test_asr();
    int lat; logic id; logic [WIDTH-1:0] data; logic err; logic ok;
    runCmd(1, OP_ASR, 4'b1101, 3'd3, lat, id, data, err, ok);
    checkCount++; if (ok !== 1'b1 || lat != 4) $display("FAIL asr_latency got %0d (ok %b) want 4", lat, ok); else passCount++;
    checkCount++; if (id !== 1'b1 || data !== 4'b1111 || err !== 1'b0) $display("FAIL asr_result got id%b d%b e%b want id1 d1111 e0", id, data, err); else passCount++;
  endtask

  task automatic test_lsl_saturate();
    int lat; logic id; logic [WIDTH-1:0] data; logic err; logic ok;
    runCmd(0, OP_LSL, 4'b1011, 3'd5, lat, id, data, err, ok);
    checkCount++; if (ok !== 1'b1 || lat != 5) $display("FAIL lsl5_latency got %0d (ok %b) want 5", lat, ok); else passCount++;
    checkCount++; if (data !== 4'b0000 || err !== 1'b0) $display("FAIL lsl5_result got d%b e%b want d0000 e0", data, err); else passCount++;
    runCmd(0, OP_LSL, 4'b1011, 3'd0, lat, id, data, err, ok);
    checkCount++; if (ok !== 1'b1 || lat != 1) $display("FAIL lsl0_latency got %0d (ok %b) want 1", lat, ok); else passCount++;
    checkCount++; if (data !== 4'b1011 || err !== 1'b0) $display("FAIL lsl0_result got d%b e%b want d1011 e0", data, err); else passCount++;
  endtask

  task automatic test_rotate_and_illegal();
    int lat; logic id; logic [WIDTH-1:0] data; logic err; logic ok;
    runCmd(0, OP_ROL, 4'b1001, 3'd1, lat, id, data, err, ok);
`ifdef SHIFT_SEQ_ROTATE_EN
    checkCount++; if (ok !== 1'b1 || lat != 2) $display("FAIL rol_latency got %0d (ok %b) want 2", lat, ok); else passCount++;
    checkCount++; if (data !== 4'b0011 || err !== 1'b0) $display("FAIL rol_result got d%b e%b want d0011 e0", data, err); else passCount++;
`else
    checkCount++; if (ok !== 1'b1 || lat != 1) $display("FAIL rol_latency got %0d (ok %b) want 1", lat, ok); else passCount++;
    checkCount++; if (data !== 4'b1001 || err !== 1'b1) $display("FAIL rol_result got d%b e%b want d1001 e1", data, err); else passCount++;
`endif
    runCmd(1, OP_ROR, 4'b0001, 3'd6, lat, id, data, err, ok);
`ifdef SHIFT_SEQ_ROTATE_EN
    checkCount++; if (ok !== 1'b1 || lat != 7) $display("FAIL ror6_latency got %0d (ok %b) want 7", lat, ok); else passCount++;
    checkCount++; if (data !== 4'b0100 || err !== 1'b0) $display("FAIL ror6_result got d%b e%b want d0100 e0", data, err); else passCount++;
`else
    checkCount++; if (ok !== 1'b1 || lat != 1) $display("FAIL ror6_latency got %0d (ok %b) want 1", lat, ok); else passCount++;
    checkCount++; if (data !== 4'b0001 || err !== 1'b1) $display("FAIL ror6_result got d%b e%b want d0001 e1", data, err); else passCount++;
`endif
    runCmd(0, OP_ILLEGAL_6, 4'b0110, 3'd2, lat, id, data, err, ok);
    checkCount++; if (ok !== 1'b1 || lat != 1) $display("FAIL ill_latency got %0d (ok %b) want 1", lat, ok); else passCount++;
    checkCount++; if (data !== 4'b0110 || err !== 1'b1) $display("FAIL ill_result got d%b e%b want d0110 e1", data, err); else passCount++;
  endtask

  task automatic test_reset_mid_shift();
    logic got;
    logic seen;
    @(negedge clk);
    driveReq(0, 1'b1, OP_LSL, 4'b0001, 3'd3);
    #1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req0_ready) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    checkCount++; if (got !== 1'b1) $display("FAIL rst_accept got timeout want req0_ready"); else passCount++;
    @(negedge clk);
    driveReq(0, 1'b0, OP_LSL, 4'b0001, 3'd3);
    #1;
    checkCount++; if (bus.busy !== 1'b1) $display("FAIL rst_in_shift got busy %b want 1", bus.busy); else passCount++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCount++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 4'b0000) $display("FAIL rst_after got b%b v%b d%b want b0 v0 d0000", bus.busy, bus.rsp_valid, bus.rsp_data); else passCount++;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    checkCount++; if (seen !== 1'b0) $display("FAIL rst_no_response got rsp_valid want none"); else passCount++;
    @(negedge clk);
    driveReq(0, 1'b1, OP_LSR, 4'b0110, 3'd0);
    driveReq(1, 1'b1, OP_LSR, 4'b1001, 3'd0);
    #1;
    checkCount++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) $display("FAIL rst_tie got r0%b r1%b want r0 1 r1 0", bus.req0_ready, bus.req1_ready); else passCount++;
    @(negedge clk);
    driveReq(0, 1'b0, OP_LSR, 4'b0110, 3'd0);
    driveReq(1, 1'b0, OP_LSR, 4'b1001, 3'd0);
    #1;
    checkCount++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_data !== 4'b0110) $display("FAIL rst_tie_rsp got v%b id%b d%b want v1 id0 d0110", bus.rsp_valid, bus.rsp_id, bus.rsp_data); else passCount++;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
  endtask

  initial begin
    driveReq(0, 1'b0, 3'b000, '0, '0);
    driveReq(1, 1'b0, 3'b000, '0, '0);
    bus.rsp_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_lsr();
    test_asr();
    test_lsl_saturate();
    test_rotate_and_illegal();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got time limit want completion (%0d/%0d)", passCount, checkCount);
    $fatal(1, "watchdog");
  end

endmodule
